updown_counter_mod: RTL
=======================

# updown_counter_mod

Parametrised up/down counter with programmable modulus, parallel load, count enable, wrap or saturate mode, a registered terminal-count pulse and a sticky overflow flag. Successor to the fixed 4-bit wrap-around up/down counter. Driven from the divided clock and meant to be cascaded, through its terminal-count output, into display and timer chains.

## Interface
- WIDTH, 4, counter width in bits, at least 2.
- clock_div  in  1  counting clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  count enable; when 0, count holds unless load is high.
- up_down  in  1  1 = count up, 0 = count down.
- sat_mode  in  1  0 = wrap at bounds, 1 = saturate at bounds.
- load  in  1  synchronous parallel load.
- load_value  in  WIDTH  value to load.
- max_value  in  WIDTH  upper bound; legal range is 0..max_value.
- clr_ovf  in  1  clears the sticky overflow flag.
- count  out  WIDTH  current count.
- tc  out  1  one-cycle terminal-count pulse.
- ovf  out  1  sticky overflow/underflow flag.

## Operation
- Reset asserted (reset = 0): count = 0, tc = 0, ovf = 0 immediately. Reset is independent of clock_div. Deassertion is synchronised upstream.
- Priority per edge: reset, then load, then enable step, then hold.
- Load: count <= min(load_value, max_value). tc <= 0. ovf is unchanged. Load overrides enable.
- Up step:
  - count < max_value: count + 1.
  - count == max_value: wrap mode gives 0; saturate mode holds max_value.
  - In both cases at count == max_value, tc <= 1 and ovf is set.
- Down step:
  - count > 0: count - 1.
  - count == 0: wrap mode gives max_value; saturate mode holds 0.
  - In both cases at count == 0, tc <= 1 and ovf is set.
- Out of range (count > max_value, because max_value was lowered at run time):
  - Up step: wrap mode gives 0; saturate mode gives max_value. tc = 1, ovf set.
  - Down step: count <= max_value, no tc, no ovf.
- max_value = 0: count stays 0. Every enabled step pulses tc and sets ovf.
- Hold (enable = 0, load = 0): count unchanged, tc <= 0.
- ovf:
  - Set by any bound event.
  - Cleared by clr_ovf.
  - Set and clear in the same cycle: set wins.
  - load does not affect ovf.
- Arithmetic:
  - Unsigned.
  - Compares are WIDTH-bit.
  - Never relies on natural 2^WIDTH rollover, because the bound is always max_value.
- up_down, sat_mode and max_value may change on any cycle. They take effect at the next edge.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Count latency: inputs sampled at edge N appear on count after edge N.
- tc is high for exactly the cycle following the bound event.
  - Back-to-back bound events (for example saturated while enabled) keep tc high continuously.
- ovf rises in the same cycle as tc.
- Reset mid-count: count returns to 0 asynchronously. The first enabled up edge after release gives 1.

## Structure
- Package counter_pkg holds:
  - Localparam MODE_WRAP = 1'b0 and MODE_SAT = 1'b1.
  - Localparam DIR_DOWN = 1'b0 and DIR_UP = 1'b1.
  - A shared WIDTH default.
- One combinational sub-module, updown_next_value (parameter WIDTH).
  - Inputs: count, up_down, sat_mode, max_value.
  - Outputs: next count and a bound-event flag.
- The top level holds the registers, the load/enable priority and ovf.

## Test plan
All scenarios use WIDTH = 4.
- Reset and up wrap: enable = 1, up_down = 1, max_value = 9, sat_mode = 0, 12 edges -> count 1..9, 0, 1, 2; tc high only in the cycle after 9→0; ovf = 1 afterwards.
- Down wrap and saturate: load 0, up_down = 0, max_value = 5.
  - Wrap mode -> count 5, 4; tc pulses once.
  - Repeat with sat_mode = 1 -> count stays 0; tc high on every enabled edge.
- Load clamp and priority: max_value = 7, load = 1, load_value = 12, enable = 1 -> count = 7 with no step; tc = 0; ovf unchanged.
- Runtime bound lowering: count = 10, set max_value = 3.
  - Up step in wrap mode -> count 0, tc = 1.
  - Separately, a down step -> count 3, tc = 0.
- ovf set/clear collision: assert clr_ovf on the same edge as a 15→0 wrap (max_value = 15) -> ovf stays 1. clr_ovf alone on the next edge -> ovf = 0.
- Async reset mid-operation: pull reset low between edges while count = 6 -> count, tc and ovf are 0 before the next edge. Release, enable up -> 1, 2.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared mode/direction encodings and default width for the up/down counter
package counter_pkg;
    localparam int  COUNTER_WIDTH = 4;
    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_SAT     = 1'b1;
    localparam logic DIR_DOWN     = 1'b0;
    localparam logic DIR_UP       = 1'b1;
endpackage

// File: rtl/updown_next_value.sv
// updown_next_value: combinational step of the counter against a programmable bound
//   count      in  current count
//   up_down    in  1 = up, 0 = down
//   sat_mode   in  0 = wrap, 1 = saturate
//   max_value  in  upper bound of the legal range 0..max_value
//   next_count out value after one enabled step
//   bound      out step hit a bound (drives tc and ovf)
module updown_next_value
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_down,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] max_value,
    output logic [WIDTH-1:0] next_count,
    output logic             bound
);
    logic [WIDTH-1:0] up_val, dn_val;
    logic             up_hit, dn_hit, over;
    // >= also catches a count left above a bound that was lowered at run time
    assign up_hit = count >= max_value;
    assign over   = count > max_value;
    // an out-of-range count steps down straight into range without a bound event
    assign dn_hit = !over && count == '0;
    assign up_val = up_hit ? (sat_mode == MODE_SAT ? max_value : '0) : count + 1'b1;
    assign dn_val = over ? max_value : dn_hit ? (sat_mode == MODE_SAT ? '0 : max_value) : count - 1'b1;
    assign next_count = up_down == DIR_UP ? up_val : dn_val;
    assign bound      = up_down == DIR_UP ? up_hit : dn_hit;
endmodule

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: up/down counter with modulus, load, wrap/saturate, tc pulse and sticky ovf
//   clock_div  in  counting clock
//   reset      in  asynchronous active-low reset
//   enable     in  count enable
//   up_down    in  1 = up, 0 = down
//   sat_mode   in  0 = wrap, 1 = saturate
//   load       in  synchronous parallel load (overrides enable)
//   load_value in  value to load, clamped to max_value
//   max_value  in  upper bound
//   clr_ovf    in  clears ovf (a simultaneous bound event wins)
//   count      out current count
//   tc         out registered terminal-count pulse
//   ovf        out sticky overflow/underflow flag
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clock_div,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max_value,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);
    logic [WIDTH-1:0] count_q, count_d, step_val;
    logic             tc_q, tc_d, ovf_q, ovf_d, bound, step;

    updown_next_value #(.WIDTH(WIDTH)) u_next (
        .count      (count_q),
        .up_down    (up_down),
        .sat_mode   (sat_mode),
        .max_value  (max_value),
        .next_count (step_val),
        .bound      (bound)
    );

    assign step = enable && !load;

    always_comb begin
        count_d = load ? (load_value > max_value ? max_value : load_value) : step ? step_val : count_q;
        tc_d    = step && bound;
        ovf_d   = (step && bound) || (ovf_q && !clr_ovf);
    end

    always_ff @(posedge clock_div or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
endmodule
